// File: rtl/l1_lookup_arb_pkg.sv
// Shared definitions for the L1 lookup arbiter: index width, FSM states and
// lookup-source encodings.
package l1_lookup_arb_pkg;

  localparam int CORE_IDX_WIDTH = 6;
  localparam int STARVE_W       = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic SRC_CORE = 1'b0;
  localparam logic SRC_FILL = 1'b1;

endpackage

// File: rtl/l1_lookup_arb_starve_cnt.sv
// Saturating core-starvation counter with increment, clear and a compare
// against the forced-win limit.
module l1_starve_cnt
  import l1_lookup_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  logic [STARVE_W-1:0] r_cnt;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // state uses non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == LIMIT[STARVE_W-1:0]);

endmodule

// File: rtl/l1_lookup_arb.sv
// Arbitrates core lookups against refill requests for the shared tag/LRU
// stage, holding a set lock while a refill is in flight.
module l1_lookup_arb
  import l1_lookup_arb_pkg::*;
#(
  parameter int IDX_W      = CORE_IDX_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_req,
  input  logic [IDX_W-1:0] c_idx,
  output logic             c_gnt,
  input  logic             f_req,
  input  logic [IDX_W-1:0] f_idx,
  output logic             f_gnt,
  input  logic             f_done,
  output logic             lk_req,
  output logic [IDX_W-1:0] lk_idx,
  input  logic             lk_ready,
  output logic             lk_val_r,
  output logic             lk_src_r,
  output logic             err
);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_eff_state;
  logic [IDX_W-1:0] r_lock_idx;
  logic             w_c_gnt;
  logic             w_f_gnt;
  logic             w_starve_hit;

  // The cycle lk_ready is first seen already arbitrates as RUN; reset or a
  // dropped lk_ready silences every grant immediately.
  always_comb begin
    w_eff_state = r_state;
    if (!rst_n || !lk_ready) begin
      w_eff_state = INIT;
    end else if (r_state == INIT) begin
      w_eff_state = RUN;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_c_gnt = 1'b0;
    w_f_gnt = 1'b0;
    unique case (w_eff_state)
      RUN: begin
        w_f_gnt = f_req && !(c_req && w_starve_hit);
        w_c_gnt = c_req && !w_f_gnt;
      end
      LOCKED:  w_c_gnt = c_req && (c_idx != r_lock_idx);
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      INIT: begin
        if (lk_ready) w_state_nxt = w_f_gnt ? LOCKED : RUN;
      end
      RUN: begin
        if (!lk_ready)    w_state_nxt = INIT;
        else if (w_f_gnt) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!lk_ready)   w_state_nxt = INIT;
        else if (f_done) w_state_nxt = RUN;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_lock_idx <= '0;
      lk_val_r   <= 1'b0;
      lk_src_r   <= SRC_CORE;
      err        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      lk_val_r <= lk_req;
      lk_src_r <= w_f_gnt ? SRC_FILL : SRC_CORE;
      if (w_f_gnt) r_lock_idx <= f_idx;
      if (f_done && ((r_state != LOCKED) || w_f_gnt)) err <= 1'b1;
    end
  end

  // Lock-blocked core cycles neither increment nor clear the starvation count.
  l1_starve_cnt #(
    .LIMIT(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (c_req && w_f_gnt),
    .i_clr     (w_c_gnt || !c_req),
    .o_at_limit(w_starve_hit)
  );

  assign c_gnt  = w_c_gnt;
  assign f_gnt  = w_f_gnt;
  assign lk_req = w_c_gnt || w_f_gnt;
  assign lk_idx = w_f_gnt ? f_idx : c_idx;

endmodule
